// File: rtl/min_window_averager.sv
// min_window_averager
// Accepts samples from the minimum stage over a 4-phase dav_/rfd handshake,
// accumulates a window of 2**LOG2N samples, then offers the truncated average
// and the window peak over a second 4-phase handshake (dav_out_/rfd_out).
// While a result is pending, rfd stays low, so upstream is held off.
// LOG2N is intended to lie in 0..4.

module min_window_averager #(
  parameter int W     = 8,
  parameter int LOG2N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         dav_,
  input  logic [W-1:0] min,
  output logic         rfd,
  output logic         dav_out_,
  input  logic         rfd_out,
  output logic [W-1:0] avg,
  output logic [W-1:0] peak
);

  // The accumulator is wide enough to hold N full-scale samples.
  // The counter has one extra bit so that it can hold the value N itself.
  localparam int ACC_W = W + LOG2N;
  localparam int CNT_W = LOG2N + 1;
  localparam int N     = 1 << LOG2N;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       pk;
  logic               window_full;

  assign window_full = (cnt == CNT_W'(N));

  // State register; reset abandons any window or pending result at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode for the two back-to-back 4-phase handshakes.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (!dav_)   next_state = S_ACK;
      S_ACK:  if (dav_)    next_state = window_full ? S_OUT : S_IDLE;
      S_OUT:  if (!rfd_out) next_state = S_DONE;
      S_DONE: if (rfd_out)  next_state = S_IDLE;
      default:              next_state = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs. The outputs are driven only
  // from flops, so no input reaches an output combinationally. min is
  // captured only in S_IDLE, so a sample is counted exactly once even if
  // dav_ stays low. avg and peak hold until the next window completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rfd      <= 1'b1;
      dav_out_ <= 1'b1;
      avg      <= '0;
      peak     <= '0;
      acc      <= '0;
      cnt      <= '0;
      pk       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!dav_) begin
            acc <= acc + ACC_W'(min);
            if (cnt == '0 || min > pk) begin
              pk <= min;
            end
            cnt <= cnt + CNT_W'(1);
            rfd <= 1'b0;
          end
        end
        S_ACK: begin
          if (dav_) begin
            if (window_full) begin
              avg      <= W'(acc >> LOG2N);
              peak     <= pk;
              dav_out_ <= 1'b0;
            end else begin
              rfd <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (!rfd_out) begin
            dav_out_ <= 1'b1;
          end
        end
        S_DONE: begin
          if (rfd_out) begin
            acc <= '0;
            cnt <= '0;
            rfd <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
